// File: rtl/ecliptic_fcompare.sv
// ecliptic_fcompare: single-precision compare / min-max unit (FEQ, FLT, FLE, FMIN, FMAX).
//
// A four-state sequencer (idle, classify, compare, done) accepts one operation per
// req/ack handshake. Operands are classified into the FPU's 10-bit class vector,
// ordered by sign-magnitude, and the result and invalid flag are registered.
//
// Ports:
//   clk   in   1   clock, all state on posedge
//   rst   in   1   asynchronous active-high reset
//   req   in   1   start request, sampled only while idle
//   op    in   3   000 FLE, 001 FLT, 010 FEQ, 100 FMIN, 101 FMAX, others illegal
//   src1  in  32   operand a (binary32)
//   src2  in  32   operand b (binary32)
//   res   out 32   compare result in bit 0, or min/max value
//   nv    out  1   invalid-operation flag, valid with ack
//   ack   out  1   one-cycle completion pulse
//   busy  out  1   high from accept through the ack cycle
module ecliptic_fcompare #(
    parameter logic [31:0] CANON_NAN = 32'h7fc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] res,
    output logic        nv,
    output logic        ack,
    output logic        busy
);

    localparam logic [2:0] OpFle  = 3'b000;
    localparam logic [2:0] OpFlt  = 3'b001;
    localparam logic [2:0] OpFeq  = 3'b010;
    localparam logic [2:0] OpFmin = 3'b100;
    localparam logic [2:0] OpFmax = 3'b101;

    // Class vector bit positions, msb..lsb.
    localparam int unsigned ClsQnan  = 9;
    localparam int unsigned ClsSnan  = 8;
    localparam int unsigned ClsPzero = 4;
    localparam int unsigned ClsNzero = 3;

    typedef enum logic [1:0] {StIdle, StClass, StCmp, StDone} state_t;

    state_t      state_q;
    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    logic [9:0]  cls_a_q, cls_b_q;
    logic        lt_q, eq_q;

    logic [9:0]  cls_a_d, cls_b_d;
    logic        lt_d, eq_d;
    logic [31:0] res_d;
    logic        nv_d;

    function automatic logic [9:0] classify(input logic [31:0] x);
        logic        sign;
        logic [7:0]  expo;
        logic [22:0] frac;
        logic        exp_ones, exp_zero, frac_zero;
        logic [9:0]  c;
        sign      = x[31];
        expo      = x[30:23];
        frac      = x[22:0];
        exp_ones  = (expo == 8'hff);
        exp_zero  = (expo == 8'h00);
        frac_zero = (frac == 23'd0);
        c         = '0;
        c[9] = exp_ones & ~frac_zero & frac[22];
        c[8] = exp_ones & ~frac_zero & ~frac[22];
        c[7] = exp_ones & frac_zero & ~sign;
        c[6] = ~exp_ones & ~exp_zero & ~sign;
        c[5] = exp_zero & ~frac_zero & ~sign;
        c[4] = exp_zero & frac_zero & ~sign;
        c[3] = exp_zero & frac_zero & sign;
        c[2] = exp_zero & ~frac_zero & sign;
        c[1] = ~exp_ones & ~exp_zero & sign;
        c[0] = exp_ones & frac_zero & sign;
        return c;
    endfunction

    always_comb begin
        cls_a_d = classify(a_q);
        cls_b_d = classify(b_q);
    end

    // Raw order flags; NaN operands produce don't-care values masked later.
    logic both_zero;
    always_comb begin
        both_zero = (cls_a_q[ClsPzero] | cls_a_q[ClsNzero]) &
                    (cls_b_q[ClsPzero] | cls_b_q[ClsNzero]);
        eq_d = (a_q == b_q) | both_zero;
        lt_d = 1'b0;
        unique case ({a_q[31], b_q[31]})
            2'b00:   lt_d = (a_q[30:0] < b_q[30:0]);
            2'b11:   lt_d = (a_q[30:0] > b_q[30:0]);
            2'b10:   lt_d = ~both_zero;
            default: lt_d = 1'b0;
        endcase
    end

    // Result selection from registered class and order flags.
    logic a_nan, b_nan, any_nan, any_snan, zero_pair;
    logic lt_z, gt_z;
    always_comb begin
        a_nan     = cls_a_q[ClsQnan] | cls_a_q[ClsSnan];
        b_nan     = cls_b_q[ClsQnan] | cls_b_q[ClsSnan];
        any_nan   = a_nan | b_nan;
        any_snan  = cls_a_q[ClsSnan] | cls_b_q[ClsSnan];
        zero_pair = (cls_a_q[ClsPzero] | cls_a_q[ClsNzero]) &
                    (cls_b_q[ClsPzero] | cls_b_q[ClsNzero]);
        // Min/max ordering where -0 sorts below +0.
        lt_z = lt_q | (zero_pair & a_q[31] & ~b_q[31]);
        gt_z = (~lt_q & ~eq_q) | (zero_pair & ~a_q[31] & b_q[31]);
        res_d = 32'd0;
        nv_d  = 1'b0;
        case (op_q)
            OpFeq: begin
                res_d[0] = eq_q & ~any_nan;
                nv_d     = any_snan;
            end
            OpFlt: begin
                res_d[0] = lt_q & ~any_nan;
                nv_d     = any_nan;
            end
            OpFle: begin
                res_d[0] = (lt_q | eq_q) & ~any_nan;
                nv_d     = any_nan;
            end
            OpFmin, OpFmax: begin
                nv_d = any_snan;
                if (a_nan && b_nan) begin
                    res_d = CANON_NAN;
                end else if (a_nan) begin
                    res_d = b_q;
                end else if (b_nan) begin
                    res_d = a_q;
                end else if (op_q == OpFmin) begin
                    res_d = gt_z ? b_q : a_q;
                end else begin
                    res_d = lt_z ? b_q : a_q;
                end
            end
            default: begin
                res_d = 32'd0;
                nv_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cls_a_q <= '0;
            cls_b_q <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            res     <= '0;
            nv      <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        a_q     <= src1;
                        b_q     <= src2;
                        op_q    <= op;
                        busy    <= 1'b1;
                        state_q <= StClass;
                    end else begin
                        // Clears busy the cycle after the ack pulse.
                        busy <= 1'b0;
                    end
                end
                StClass: begin
                    cls_a_q <= cls_a_d;
                    cls_b_q <= cls_b_d;
                    state_q <= StCmp;
                end
                StCmp: begin
                    lt_q    <= lt_d;
                    eq_q    <= eq_d;
                    state_q <= StDone;
                end
                StDone: begin
                    res     <= res_d;
                    nv      <= nv_d;
                    ack     <= 1'b1;
                    busy    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ecliptic_fcompare.sv
module tb_ecliptic_fcompare;

    localparam logic [31:0] CANON = 32'h7fc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  op;
    logic [31:0] src1, src2;
    logic [31:0] res;
    logic        nv, ack, busy;

    int checks = 0;
    int errors = 0;

    ecliptic_fcompare #(.CANON_NAN(CANON)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .op   (op),
        .src1 (src1),
        .src2 (src2),
        .res  (res),
        .nv   (nv),
        .ack  (ack),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value of a binary32 as a real; infinities map to a huge finite magnitude.
    function automatic real to_real(input logic [31:0] x);
        int  e;
        real mag;
        e = int'(x[30:23]);
        if (e == 255)    mag = 1.0e300;
        else if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
        else             mag = (real'(x[22:0]) + 8388608.0) * (2.0 ** (e - 150));
        return x[31] ? -mag : mag;
    endfunction

    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

    function automatic bit is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic n);
        real ra, rb;
        bit  an, sn;
        ra = to_real(a);
        rb = to_real(b);
        an = is_nan(a) || is_nan(b);
        sn = is_snan(a) || is_snan(b);
        r  = 32'd0;
        n  = 1'b0;
        case (o)
            3'b010: begin r[0] = !an && (ra == rb); n = sn; end
            3'b001: begin r[0] = !an && (ra < rb);  n = an; end
            3'b000: begin r[0] = !an && (ra <= rb); n = an; end
            3'b100, 3'b101: begin
                n = sn;
                if (is_nan(a) && is_nan(b)) r = CANON;
                else if (is_nan(a)) r = b;
                else if (is_nan(b)) r = a;
                else if (ra < rb) r = (o == 3'b100) ? a : b;
                else if (ra > rb) r = (o == 3'b100) ? b : a;
                else if (is_zero(a) && is_zero(b) && (a[31] != b[31]))
                    r = ((o == 3'b100) == a[31]) ? a : b;
                else r = a;
            end
            default: begin r = 32'd0; n = 1'b0; end
        endcase
    endtask

    // Issue one operation, check handshake latency, then check result against the model.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] er;
        logic        en;
        int          lat;
        @(negedge clk);
        req = 1'b1; op = o; src1 = a; src2 = b;
        @(posedge clk);
        #1;
        req = 1'b0;
        check({tag, "/busy_accept"}, {31'd0, busy}, 32'd1);
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                lat = c;
                break;
            end
        end
        check({tag, "/latency"}, lat, 32'd3);
        check({tag, "/busy_ack"}, {31'd0, busy}, 32'd1);
        model(o, a, b, er, en);
        check({tag, "/res"}, res, er);
        check({tag, "/nv"}, {31'd0, nv}, {31'd0, en});
    endtask

    function automatic logic [31:0] pick_operand(input logic [31:0] other);
        logic [31:0] sp [10];
        int          k;
        sp[0] = 32'h00000000; sp[1] = 32'h80000000; sp[2] = 32'h7f800000;
        sp[3] = 32'hff800000; sp[4] = 32'h7fc00000; sp[5] = 32'h7f800001;
        sp[6] = 32'h00000001; sp[7] = 32'h807fffff; sp[8] = 32'h3f800000;
        sp[9] = 32'hffa00000;
        k = $urandom_range(0, 9);
        if (k < 3) return sp[$urandom_range(0, 9)];
        if (k == 3) return other;
        if (k == 4) return other ^ 32'h80000000;
        if (k == 5) return other + 32'($urandom_range(0, 2)) - 32'd1;
        return $urandom();
    endfunction

    initial begin
        logic [2:0]  ops [8];
        logic [31:0] a, b;
        int          ack_cnt, first_ack, last_ack, gap_bad, busy_low;
        ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100;
        ops[4] = 3'b101; ops[5] = 3'b011; ops[6] = 3'b110; ops[7] = 3'b111;

        rst = 1'b1; req = 1'b0; op = 3'b000; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/res", res, 32'd0);
        check("reset/nv", {31'd0, nv}, 32'd0);
        check("reset/ack", {31'd0, ack}, 32'd0);
        check("reset/busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Leave res=1 so the mid-op reset visibly clears it.
        run_op("flt_pos", 3'b001, 32'h3f800000, 32'h40000000);
        check("flt_pos/ack_pulse_hold", res, 32'd1);
        @(posedge clk);
        #1;
        check("ack_one_cycle", {31'd0, ack}, 32'd0);

        // Reset while in the classify state.
        @(negedge clk);
        req = 1'b1; op = 3'b001; src1 = 32'hbf800000; src2 = 32'h3f800000;
        @(posedge clk);
        #1;
        req = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        ack_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (ack) ack_cnt++;
        end
        check("midreset/acks", ack_cnt, 32'd0);
        check("midreset/res", res, 32'd0);
        check("midreset/nv", {31'd0, nv}, 32'd0);
        check("midreset/busy", {31'd0, busy}, 32'd0);

        run_op("flt_neg", 3'b001, 32'hc0000000, 32'hbf800000);
        run_op("feq_zeros", 3'b010, 32'h80000000, 32'h00000000);
        run_op("feq_snan", 3'b010, 32'h80000000, 32'h7f800001);
        run_op("fle_qnan", 3'b000, 32'h80000000, 32'h7fc00000);
        run_op("fmin_zeros", 3'b100, 32'h00000000, 32'h80000000);
        run_op("fmax_zeros", 3'b101, 32'h00000000, 32'h80000000);
        run_op("fmax_snan", 3'b101, 32'h7f800001, 32'h3f800000);
        run_op("fmin_nans", 3'b100, 32'h7fc00000, 32'hff800001);
        run_op("fmin_eq", 3'b100, 32'h40490fdb, 32'h40490fdb);
        run_op("illegal", 3'b111, 32'h3f800000, 32'h40000000);

        // req held high: one ack every 4 cycles, busy never drops.
        @(negedge clk);
        req = 1'b1; op = 3'b101; src1 = 32'h3f800000; src2 = 32'h40000000;
        ack_cnt = 0; first_ack = -1; last_ack = -1; gap_bad = 0; busy_low = 0;
        for (int c = 0; c < 17; c++) begin
            @(posedge clk);
            #1;
            if (!busy) busy_low++;
            if (ack) begin
                if (first_ack < 0) first_ack = c;
                else if (c - last_ack != 4) gap_bad++;
                last_ack = c;
                ack_cnt++;
            end
        end
        @(negedge clk);
        req = 1'b0;
        check("b2b/acks", ack_cnt, 32'd4);
        check("b2b/first_ack", first_ack, 32'd3);
        check("b2b/gap", gap_bad, 32'd0);
        check("b2b/busy", busy_low, 32'd0);
        check("b2b/res", res, 32'h40000000);
        repeat (4) @(posedge clk);

        for (int i = 0; i < 150; i++) begin
            a = pick_operand($urandom());
            b = pick_operand(a);
            run_op($sformatf("rand%0d", i), ops[$urandom_range(0, 7)], a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecliptic_fcompare.md
Name: ecliptic_fcompare

Overview:
- Single-precision compare / min-max unit (FEQ, FLT, FLE, FMIN, FMAX, RISC-V F semantics).
- Sits directly downstream of the FP classification stage in the FPU datapath and uses the same 10-bit class vector.
- Computes the class vector of both operands internally, then orders them and produces the result plus the invalid flag.
- Multi-cycle FSM with a req/ack handshake toward the FPU issue logic.

Parameters:
- CANON_NAN, 32'h7fc00000, canonical quiet NaN returned by FMIN/FMAX.

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  1  start request; sampled only in IDLE.
- op  input  3  3'b000 FLE, 3'b001 FLT, 3'b010 FEQ, 3'b100 FMIN, 3'b101 FMAX; other codes illegal.
- src1  input  32  operand a, IEEE-754 binary32.
- src2  input  32  operand b, IEEE-754 binary32.
- res  output  32  result: compares give 0/1 in bit0, min/max give a binary32 value.
- nv  output  1  invalid-operation flag, valid while ack=1.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high from accept until the ack cycle, inclusive.

Behaviour:
- Reset (async, rst=1): state=IDLE; res=0, nv=0, ack=0, busy=0; internal operand, op and class registers cleared. Deasserting reset mid-operation leaves the block in IDLE with no ack.
- Class vector per operand, 10 bits, msb..lsb: {qnan, snan, pinf, pnml, psnml, pzero, nzero, nsnml, nnml, ninf}. Exactly one bit set.
- FSM, always in this order:
  - IDLE: if req=1, latch src1, src2 and op; set busy=1; go to CLASS. Otherwise stay, ack=0.
  - CLASS: register the class vectors of both latched operands; go to CMP.
  - CMP: compute the raw order flags lt and eq:
    - eq is 1 if bit patterns are equal or both operands are zero (-0 == +0).
    - lt uses sign-magnitude order. Both positive: a<b when mag_a<mag_b. Both negative: a<b when mag_a>mag_b. Mixed signs: the negative operand is smaller, except that two zeros are never lt.
    - Go to DONE.
  - DONE: drive res/nv; ack=1 for this cycle only; busy=1; next state is IDLE.
- Latency: req accepted at posedge N gives ack=1 in the cycle after posedge N+3. Throughput is one operation per 4 cycles.
- req while busy is ignored and not queued; the requester must hold or re-issue req after ack. req=1 in the DONE cycle is not accepted; it is accepted on the next posedge if still high in IDLE.
- res and nv hold their DONE values after ack falls, until the next operation's DONE cycle.
- NaN is anan = class[9]|class[8], sNaN is class[8].
- FEQ: res = eq & ~anyNaN; nv = any sNaN.
- FLT: res = lt & ~anyNaN; nv = any NaN.
- FLE: res = (lt|eq) & ~anyNaN; nv = any NaN.
- FMIN/FMAX:
  - Both operands NaN: res = CANON_NAN.
  - One operand NaN: res = the other operand.
  - Otherwise, FMIN returns the smaller operand and FMAX the larger.
  - Signed zeros: -0 is treated as less than +0, so FMIN(+0,-0) = -0 and FMAX(-0,+0) = +0.
  - Equal non-zero operands: return src1.
  - nv = any sNaN.
- Illegal op: res = 0, nv = 0; ack still issued with normal latency.
- Results are bit-exact and do not depend on rounding mode.

Test Plan:
- Reset mid-op: req with FLT while rst pulses in the CLASS state -> after release, state IDLE, ack never pulses, res=0, nv=0, busy=0.
- FLT src1=0x3f800000 (1.0), src2=0x40000000 (2.0) -> ack at accept+3 cycles, res=1, nv=0; same op with src1=0xc0000000 (-2.0), src2=0xbf800000 (-1.0) -> res=1.
- FEQ src1=0x80000000, src2=0x00000000 -> res=1, nv=0; FEQ with src2=0x7f800001 (sNaN) -> res=0, nv=1; FLE with src2=0x7fc00000 (qNaN) -> res=0, nv=1.
- FMIN src1=0x00000000, src2=0x80000000 -> res=0x80000000; FMAX on the same operands -> res=0x00000000; nv=0 in both cases.
- FMAX src1=0x7f800001, src2=0x3f800000 -> res=0x3f800000, nv=1; FMIN src1=0x7fc00000, src2=0xff800001 -> res=0x7fc00000, nv=1.
- Back-to-back: req held high continuously -> one ack every 4 cycles, req in the busy cycles ignored. op=3'b111 -> res=0, nv=0, ack issued.
